// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester arbiter in front of a single-port data memory.
// Optional DMEM_ARB_ROUND_ROBIN_EN selects round-robin ties instead of port 0 priority.
module dmem_arbiter #(
   parameter int unsigned WORDS = 128
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        req0_valid,
   input  logic        req0_we,
   input  logic [31:0] req0_addr,
   input  logic [31:0] req0_wdata,
   input  logic        req0_lock,
   output logic        req0_ready,
   output logic        rsp0_valid,
   output logic [31:0] rsp0_rdata,
   output logic        rsp0_err,
   input  logic        req1_valid,
   input  logic        req1_we,
   input  logic [31:0] req1_addr,
   input  logic [31:0] req1_wdata,
   input  logic        req1_lock,
   output logic        req1_ready,
   output logic        rsp1_valid,
   output logic [31:0] rsp1_rdata,
   output logic        rsp1_err,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam logic [29:0] WORDS_W = 30'(WORDS);

   typedef enum logic [1:0] {
      IDLE,
      OWN0,
      OWN1
   } state_t;

   state_t      state_q, state_d;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
   logic        ptr_q, ptr_d;
`endif
   logic        rsp0_valid_q, rsp0_valid_d;
   logic [31:0] rsp0_rdata_q, rsp0_rdata_d;
   logic        rsp0_err_q, rsp0_err_d;
   logic        rsp1_valid_q, rsp1_valid_d;
   logic [31:0] rsp1_rdata_q, rsp1_rdata_d;
   logic        rsp1_err_q, rsp1_err_d;

   logic        gnt0, gnt1, any_gnt;
   logic        win_we, win_lock, in_range;
   logic [31:0] win_addr, win_wdata;

   // Pick at most one winner; a locked owner excludes the other port.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!RST) begin
         unique case (state_q)
            IDLE: begin
               if (req0_valid && req1_valid) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                  gnt0 = !ptr_q;
                  gnt1 = ptr_q;
`else
                  gnt0 = 1'b1;
`endif
               end else begin
                  gnt0 = req0_valid;
                  gnt1 = req1_valid;
               end
            end
            OWN0:    gnt0 = req0_valid;
            OWN1:    gnt1 = req1_valid;
            default: ;
         endcase
      end
   end

   // Route the winner onto the memory port; idle port drives zeros.
   always_comb begin
      win_we    = 1'b0;
      win_lock  = 1'b0;
      win_addr  = 32'd0;
      win_wdata = 32'd0;
      if (gnt0) begin
         win_we    = req0_we;
         win_lock  = req0_lock;
         win_addr  = req0_addr;
         win_wdata = req0_wdata;
      end else if (gnt1) begin
         win_we    = req1_we;
         win_lock  = req1_lock;
         win_addr  = req1_addr;
         win_wdata = req1_wdata;
      end
   end

   assign any_gnt    = gnt0 | gnt1;
   assign in_range   = win_addr[31:2] < WORDS_W;
   assign req0_ready = gnt0;
   assign req1_ready = gnt1;
   assign mem_we     = any_gnt & win_we & in_range;
   assign mem_addr   = win_addr;
   assign mem_wdata  = win_wdata;

   // Ownership FSM, tie pointer and next response values.
   always_comb begin
      state_d      = state_q;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      ptr_d        = ptr_q;
      if (any_gnt) ptr_d = gnt0;
`endif
      unique case (state_q)
         IDLE: begin
            if (gnt0 && req0_lock) state_d = OWN0;
            else if (gnt1 && req1_lock) state_d = OWN1;
         end
         OWN0:    if (gnt0 && !req0_lock) state_d = IDLE;
         OWN1:    if (gnt1 && !req1_lock) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      rsp0_valid_d = gnt0;
      rsp0_err_d   = gnt0 & !in_range;
      rsp0_rdata_d = (gnt0 && !win_we && in_range) ? mem_rdata : 32'd0;
      rsp1_valid_d = gnt1;
      rsp1_err_d   = gnt1 & !in_range;
      rsp1_rdata_d = (gnt1 && !win_we && in_range) ? mem_rdata : 32'd0;
   end

   // State and response registers; reset drops any in-flight response.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q      <= IDLE;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
         ptr_q        <= 1'b0;
`endif
         rsp0_valid_q <= 1'b0;
         rsp0_rdata_q <= 32'd0;
         rsp0_err_q   <= 1'b0;
         rsp1_valid_q <= 1'b0;
         rsp1_rdata_q <= 32'd0;
         rsp1_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
         ptr_q        <= ptr_d;
`endif
         rsp0_valid_q <= rsp0_valid_d;
         rsp0_rdata_q <= rsp0_rdata_d;
         rsp0_err_q   <= rsp0_err_d;
         rsp1_valid_q <= rsp1_valid_d;
         rsp1_rdata_q <= rsp1_rdata_d;
         rsp1_err_q   <= rsp1_err_d;
      end
   end

   assign rsp0_valid = rsp0_valid_q;
   assign rsp0_rdata = rsp0_rdata_q;
   assign rsp0_err   = rsp0_err_q;
   assign rsp1_valid = rsp1_valid_q;
   assign rsp1_rdata = rsp1_rdata_q;
   assign rsp1_err   = rsp1_err_q;

endmodule
